button_conditioner: RTL and testbench

//  Front-end conditioning for the operand-entry panel. Synchronises the raw active-low push

---
 rtl/button_conditioner_pkg.sv | 32 +++
 rtl/button_conditioner_if.sv | 40 ++++
 rtl/button_conditioner_debounce_cell.sv | 138 +++++++++++++
 rtl/button_conditioner.sv | 65 ++++++
 tb/tb_button_conditioner.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the operand-entry button conditioner.
//   Holds the debounce FSM state encoding, the default debounce length and
//   the values every flop takes while reset_n is low.
// -----------------------------------------------------------------------------
package btn_pkg;

  // Two-bit state encoding. Bit 1 set means the debounced level is "pressed".
  localparam logic [1:0] ST_UP        = 2'b00;
  localparam logic [1:0] ST_DOWN_WAIT = 2'b01;
  localparam logic [1:0] ST_DOWN      = 2'b11;
  localparam logic [1:0] ST_UP_WAIT   = 2'b10;

  typedef enum logic [1:0] {
    UP        = ST_UP,
    DOWN_WAIT = ST_DOWN_WAIT,
    DOWN      = ST_DOWN,
    UP_WAIT   = ST_UP_WAIT
  } btn_state_e;

  // Number of consecutive stable synchronised samples needed to accept a change.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Reset values: buttons idle high (released), data switches read as zero,
  // level and strobe outputs inactive (high).
  localparam logic BTN_SYNC_RST  = 1'b1;
  localparam logic DATA_SYNC_RST = 1'b0;
  localparam logic LEVEL_N_RST   = 1'b1;
  localparam logic PRESS_N_RST   = 1'b1;

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the raw panel inputs and the conditioned outputs of the button
//   conditioner.
//     btn_raw_n   [NUM_BTN] raw active-low buttons (asynchronous, bouncing)
//     data_raw    [DATA_W]  raw data switches (asynchronous)
//     btn_level_n [NUM_BTN] debounced active-low button level
//     btn_press_n [NUM_BTN] one-cycle active-low press strobe
//     data_sync   [DATA_W]  synchronised data switches
//   master: the panel side (drives raw inputs, observes conditioned outputs)
//   slave : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int NUM_BTN = 3,
  parameter int DATA_W  = 4
);

  logic [NUM_BTN-1:0] btn_raw_n;
  logic [DATA_W-1:0]  data_raw;
  logic [NUM_BTN-1:0] btn_level_n;
  logic [NUM_BTN-1:0] btn_press_n;
  logic [DATA_W-1:0]  data_sync;

  modport master (
    output btn_raw_n,
    output data_raw,
    input  btn_level_n,
    input  btn_press_n,
    input  data_sync
  );

  modport slave (
    input  btn_raw_n,
    input  data_raw,
    output btn_level_n,
    output btn_press_n,
    output data_sync
  );

endinterface

// File: rtl/button_conditioner_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
//   Conditions a single raw active-low button: a SYNC_STAGES flop
//   synchroniser, a debounce counter and a four-state FSM. A change of the
//   synchronised input is accepted only after DEBOUNCE_CYCLES consecutive
//   identical samples; accepting a press emits one active-low strobe.
//   Ports:
//     clk       in  system clock
//     reset_n   in  asynchronous active-low reset
//     btn_raw_n in  raw button, active-low, asynchronous to clk
//     level_n   out debounced level, active-low (registered)
//     press_n   out one-cycle active-low press strobe (registered)
// -----------------------------------------------------------------------------
module debounce_cell
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_n,
  output logic level_n,
  output logic press_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Increment that holds at the terminal count. Transitions always fire at
  // CNT_LAST, so the hold never engages in practice; it simply makes a wrap
  // impossible.
  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (c == CNT_LAST) ? c : c + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   btn_s;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_n_q, level_n_d;
  logic             press_n_q, press_n_d;

  // ---- stage p0..pN: synchroniser (shift in at bit 0, read from the top) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= {SYNC_STAGES{BTN_SYNC_RST}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], btn_raw_n};
    end
  end

  assign btn_s = sync_p[SYNC_STAGES-1];

  // ---- stage: debounce FSM state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_n_q <= LEVEL_N_RST;
      press_n_q <= PRESS_N_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_n_q <= level_n_d;
      press_n_q <= press_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_n_d = 1'b1;
    level_n_d = 1'b1;

    unique case (state_q)
      UP: begin
        if (!btn_s) begin
          state_d = DOWN_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      DOWN_WAIT: begin
        if (btn_s) begin
          // Bounce: the press did not stay low long enough.
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DOWN;
          cnt_d     = '0;
          press_n_d = 1'b0;
        end else begin
          cnt_d = cnt_inc_sat(cnt_q);
        end
      end

      DOWN: begin
        if (btn_s) begin
          state_d = UP_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      UP_WAIT: begin
        if (!btn_s) begin
          // Release bounce: still pressed, and no fresh strobe.
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_sat(cnt_q);
        end
      end

      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase

    // Level is registered from the next state so it falls on the same edge
    // as the press strobe.
    level_n_d = ((state_d == DOWN) || (state_d == UP_WAIT)) ? 1'b0 : 1'b1;
  end

  assign level_n = level_n_q;
  assign press_n = press_n_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Front-end conditioning for the operand-entry panel. Each raw active-low
//   button gets its own debounce_cell; the data switches pass through a plain
//   SYNC_STAGES flop synchroniser (bits are synchronised independently, no
//   multi-bit coherency). Press strobes feed the operand latch save inputs and
//   data_sync feeds its data input.
//   Ports:
//     clk      in  system clock
//     reset_n  in  asynchronous active-low reset
//     bus      slave side of button_conditioner_if
//                (btn_raw_n, data_raw in; btn_level_n, btn_press_n, data_sync out)
// -----------------------------------------------------------------------------
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DATA_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] level_n_w;
  logic [NUM_BTN-1:0] press_n_w;
  logic [DATA_W-1:0]  data_p [SYNC_STAGES];

  // ---- per-button conditioning ----
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw_n (bus.btn_raw_n[g]),
      .level_n   (level_n_w[g]),
      .press_n   (press_n_w[g])
    );
  end

  // ---- stage p0..pN: data switch synchroniser ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        data_p[k] <= {DATA_W{DATA_SYNC_RST}};
      end
    end else begin
      data_p[0] <= bus.data_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        data_p[k] <= data_p[k-1];
      end
    end
  end

  assign bus.btn_level_n = level_n_w;
  assign bus.btn_press_n = press_n_w;
  assign bus.data_sync   = data_p[SYNC_STAGES-1];

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, CNT_W=3. Expected press strobes are queued with the
//   cycle they must appear on; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NB  = 3;
  localparam int DW  = 4;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int CW  = 3;
  localparam int LAT = SS + DC;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  button_conditioner_if #(.NUM_BTN(NB), .DATA_W(DW)) bus ();

  button_conditioner #(
    .NUM_BTN         (NB),
    .DATA_W          (DW),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned    cyc;
    logic [NB-1:0]  val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Called on a negedge right after the raw input change is driven: the next
  // rising edge samples it, so the strobe is visible after edge cyc+LAT.
  task automatic expect_strobe(input logic [NB-1:0] v);
    exp_t e;
    e.cyc = cyc + LAT;
    e.val = v;
    sb_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      checks++;
      assert (sb_q[0].cyc >= cyc) else begin
        errors++;
        $error("FAIL missing_strobe: observed %b expected %b at cycle %0d", bus.btn_press_n, sb_q[0].val, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
    end
    if (bus.btn_press_n !== {NB{1'b1}}) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_strobe: observed %b expected %b (cycle %0d)", bus.btn_press_n, {NB{1'b1}}, cyc);
      end
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("strobe_value", 32'(bus.btn_press_n), 32'(mon_e.val));
        check("strobe_level", 32'(bus.btn_level_n & ~mon_e.val), 32'h0);
      end
    end
  end

  initial begin
    // 1: reset with all buttons held low and switches at F
    bus.btn_raw_n = 3'b000;
    bus.data_raw  = 4'hF;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level", 32'(bus.btn_level_n), 32'h7);
    check("rst_press", 32'(bus.btn_press_n), 32'h7);
    check("rst_data",  32'(bus.data_sync),   32'h0);
    bus.btn_raw_n = 3'b111;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("data_lat1", 32'(bus.data_sync), 32'h0);
    @(negedge clk);
    check("data_lat2", 32'(bus.data_sync), 32'hF);
    repeat (4) @(negedge clk);

    // 2: clean press of button 0, then clean release
    bus.btn_raw_n = 3'b110;
    expect_strobe(3'b110);
    repeat (LAT-1) @(negedge clk);
    check("press0_early_level", 32'(bus.btn_level_n), 32'h7);
    @(negedge clk);
    check("press0_level", 32'(bus.btn_level_n), 32'h6);
    @(negedge clk);
    check("press0_width", 32'(bus.btn_press_n), 32'h7);
    check("press0_hold",  32'(bus.btn_level_n), 32'h6);
    bus.btn_raw_n = 3'b111;
    repeat (LAT-1) @(negedge clk);
    check("rel0_early_level", 32'(bus.btn_level_n), 32'h6);
    @(negedge clk);
    check("rel0_level", 32'(bus.btn_level_n), 32'h7);
    repeat (2) @(negedge clk);

    // 3: bounce on button 1 (low 3, high 1, then low held)
    bus.btn_raw_n = 3'b101;
    repeat (3) @(negedge clk);
    bus.btn_raw_n = 3'b111;
    @(negedge clk);
    bus.btn_raw_n = 3'b101;
    expect_strobe(3'b101);
    repeat (LAT-1) @(negedge clk);
    check("bounce1_early_level", 32'(bus.btn_level_n), 32'h7);
    @(negedge clk);
    check("bounce1_level", 32'(bus.btn_level_n), 32'h5);
    repeat (2) @(negedge clk);

    // 4: release of button 1 with a 2-cycle low glitch inside UP_WAIT
    bus.btn_raw_n = 3'b111;
    repeat (2) @(negedge clk);
    bus.btn_raw_n = 3'b101;
    repeat (2) @(negedge clk);
    check("rel1_glitch_level", 32'(bus.btn_level_n), 32'h5);
    bus.btn_raw_n = 3'b111;
    repeat (LAT-1) @(negedge clk);
    check("rel1_early_level", 32'(bus.btn_level_n), 32'h5);
    @(negedge clk);
    check("rel1_level", 32'(bus.btn_level_n), 32'h7);
    repeat (2) @(negedge clk);

    // 5: simultaneous press of buttons 0 and 1, data change to A
    bus.btn_raw_n = 3'b100;
    bus.data_raw  = 4'hA;
    expect_strobe(3'b100);
    @(negedge clk);
    check("data_a_lat1", 32'(bus.data_sync), 32'hF);
    @(negedge clk);
    check("data_a_lat2", 32'(bus.data_sync), 32'hA);
    repeat (LAT-2) @(negedge clk);
    check("simul_level", 32'(bus.btn_level_n), 32'h4);
    @(negedge clk);
    bus.btn_raw_n = 3'b111;
    repeat (LAT) @(negedge clk);
    check("simul_rel_level", 32'(bus.btn_level_n), 32'h7);
    repeat (2) @(negedge clk);

    // 6: reset asserted at count 3 of 4, released with button 0 still low
    bus.btn_raw_n = 3'b110;
    repeat (LAT-1) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_press", 32'(bus.btn_press_n), 32'h7);
    check("midrst_level", 32'(bus.btn_level_n), 32'h7);
    check("midrst_data",  32'(bus.data_sync),   32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_strobe(3'b110);
    repeat (LAT-1) @(negedge clk);
    check("postrst_early_level", 32'(bus.btn_level_n), 32'h7);
    @(negedge clk);
    check("postrst_level", 32'(bus.btn_level_n), 32'h6);
    bus.btn_raw_n = 3'b111;
    repeat (LAT+2) @(negedge clk);
    check("postrst_rel_level", 32'(bus.btn_level_n), 32'h7);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
